// File: rtl/lcd_frame_decoder_pkg.sv
// Shared LCD geometry, trace colour and the decoder FSM encoding.
// Used by the panel driver and the frame decoder.
package lcd_frame_decoder_pkg;

    localparam int          LCD_H_ACTIVE    = 1024;
    localparam int          LCD_V_ACTIVE    = 600;
    localparam logic [23:0] LCD_TRACE_COLOR = 24'hFFFF00;

    localparam int CNT_W = 11;
    localparam int ACC_W = 20;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic {
        SEEK  = 1'b0,
        FRAME = 1'b1
    } dec_state_e;

    function automatic cnt_t cnt_sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

    function automatic acc_t acc_sat_inc(input acc_t v);
        return (&v) ? v : v + acc_t'(1);
    endfunction

endpackage

// File: rtl/lcd_edge_sync.sv
// Two-stage input register for the LCD pins with de/vs edge detection.
// Edge flags are registered alongside the second stage, so they line up with its data.
module lcd_edge_sync #(
    parameter logic VS_IDLE = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic        vs,
    input  logic        hs,
    input  logic [23:0] rgb,
    output logic        de_s,
    output logic        vs_s,
    output logic        hs_s,
    output logic [23:0] rgb_s,
    output logic        de_rise,
    output logic        de_fall,
    output logic        vs_rise,
    output logic        vs_fall
);

    logic        de_s1;
    logic        vs_s1;
    logic        hs_s1;
    logic [23:0] rgb_s1;

    // vs comes out of reset at its idle level, so releasing reset mid-frame cannot fake an edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1   <= 1'b0;
            vs_s1   <= VS_IDLE;
            hs_s1   <= 1'b0;
            rgb_s1  <= '0;
            de_s    <= 1'b0;
            vs_s    <= VS_IDLE;
            hs_s    <= 1'b0;
            rgb_s   <= '0;
            de_rise <= 1'b0;
            de_fall <= 1'b0;
            vs_rise <= 1'b0;
            vs_fall <= 1'b0;
        end else begin
            de_s1   <= de;
            vs_s1   <= vs;
            hs_s1   <= hs;
            rgb_s1  <= rgb;
            // NOTE: non-blocking assignments make the second stage and the edge flags see the pre-edge s1 value.
            de_s    <= de_s1;
            vs_s    <= vs_s1;
            hs_s    <= hs_s1;
            rgb_s   <= rgb_s1;
            de_rise <= de_s1 & ~de_s;
            de_fall <= ~de_s1 & de_s;
            vs_rise <= vs_s1 & ~vs_s;
            vs_fall <= ~vs_s1 & vs_s;
        end
    end

endmodule

// File: rtl/lcd_frame_decoder.sv
// Panel-side LCD stream checker: measures line/frame geometry, locates trace pixels
// and posts a one-cycle per-frame summary.
module lcd_frame_decoder
    import lcd_frame_decoder_pkg::*;
#(
    parameter int          H_ACTIVE    = LCD_H_ACTIVE,
    parameter int          V_ACTIVE    = LCD_V_ACTIVE,
    parameter logic [23:0] TRACE_COLOR = LCD_TRACE_COLOR,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             lcd_de,
    input  logic             lcd_vs,
    input  logic             lcd_hs,
    input  logic [23:0]      lcd_rgb,
    output logic             trace_valid,
    output logic [CNT_W-1:0] trace_x,
    output logic [CNT_W-1:0] trace_y,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_lines,
    output logic [ACC_W-1:0] trace_cnt,
    output logic             h_err,
    output logic             v_err
);

    localparam cnt_t H_REF = cnt_t'(H_ACTIVE);
    localparam cnt_t V_REF = cnt_t'(V_ACTIVE);

    logic        de_s;
    logic        vs_s;
    logic        hs_s;
    logic [23:0] rgb_s;
    logic        de_rise;
    logic        de_fall;
    logic        vs_rise;
    logic        vs_fall;

    lcd_edge_sync #(
        .VS_IDLE (~SYNC_ACTIVE)
    ) u_edge_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .de      (lcd_de),
        .vs      (lcd_vs),
        .hs      (lcd_hs),
        .rgb     (lcd_rgb),
        .de_s    (de_s),
        .vs_s    (vs_s),
        .hs_s    (hs_s),
        .rgb_s   (rgb_s),
        .de_rise (de_rise),
        .de_fall (de_fall),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    // hs and the de rising edge are carried through the sync stage but not needed for decoding.
    logic unused_sigs;
    assign unused_sigs = &{1'b0, hs_s, de_rise};

    logic vs_act;
    logic vs_act_edge;
    logic vs_inact_edge;

    assign vs_act        = (vs_s == SYNC_ACTIVE);
    assign vs_act_edge   = SYNC_ACTIVE ? vs_rise : vs_fall;
    assign vs_inact_edge = SYNC_ACTIVE ? vs_fall : vs_rise;

    dec_state_e state;
    dec_state_e state_nxt;
    logic       count_en;
    logic       close_frame;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEEK:    if (vs_inact_edge) state_nxt = FRAME;
            FRAME:   state_nxt = FRAME;
            default: state_nxt = SEEK;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        count_en    = 1'b0;
        close_frame = 1'b0;
        if (state == FRAME) begin
            count_en    = !vs_act;
            close_frame = vs_act_edge;
        end
    end

    cnt_t x_cnt;
    cnt_t y_cnt;
    acc_t trace_acc;
    logic h_err_acc;

    logic line_end;
    logic pixel_en;
    logic trace_hit;
    logic line_bad;
    cnt_t y_after;
    logic h_err_after;

    // A vs active edge with pixels still counted in x_cnt closes that line, whether or not de fell.
    assign line_end    = (count_en && de_fall) || (close_frame && (x_cnt != '0));
    assign pixel_en    = count_en && de_s;
    assign trace_hit   = pixel_en && (rgb_s == TRACE_COLOR);
    assign line_bad    = (x_cnt != H_REF) || (&x_cnt);
    assign y_after     = line_end ? cnt_sat_inc(y_cnt) : y_cnt;
    assign h_err_after = h_err_acc | (line_end & line_bad);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            trace_acc <= '0;
            h_err_acc <= 1'b0;
        end else if (close_frame) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            trace_acc <= '0;
            h_err_acc <= 1'b0;
        end else begin
            if (line_end) begin
                x_cnt <= '0;
            end else if (pixel_en) begin
                x_cnt <= cnt_sat_inc(x_cnt);
            end
            y_cnt     <= y_after;
            h_err_acc <= h_err_after;
            if (trace_hit) begin
                trace_acc <= acc_sat_inc(trace_acc);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_x     <= '0;
            trace_y     <= '0;
            frame_done  <= 1'b0;
            frame_lines <= '0;
            trace_cnt   <= '0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
        end else begin
            trace_valid <= trace_hit;
            if (trace_hit) begin
                trace_x <= x_cnt;
                trace_y <= y_cnt;
            end
            frame_done <= close_frame;
            // Summary fields hold their value until the next frame closes.
            if (close_frame) begin
                frame_lines <= y_after;
                trace_cnt   <= trace_acc;
                h_err       <= h_err_after;
                v_err       <= (y_after != V_REF) || (&y_after);
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_decoder.sv
// Randomized bench for lcd_frame_decoder: frames are described as line-length lists and
// expected strobes/summaries are derived from that description.
module tb_lcd_frame_decoder;

    localparam int          H     = 8;
    localparam int          V     = 4;
    localparam logic [23:0] TRACE = 24'hFFFF00;
    localparam int          SAT   = 2047;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        lcd_de  = 1'b0;
    logic        lcd_vs  = 1'b1;
    logic        lcd_hs  = 1'b0;
    logic [23:0] lcd_rgb = '0;
    logic        trace_valid;
    logic [10:0] trace_x;
    logic [10:0] trace_y;
    logic        frame_done;
    logic [10:0] frame_lines;
    logic [19:0] trace_cnt;
    logic        h_err;
    logic        v_err;

    lcd_frame_decoder #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .TRACE_COLOR (TRACE),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .lcd_de      (lcd_de),
        .lcd_vs      (lcd_vs),
        .lcd_hs      (lcd_hs),
        .lcd_rgb     (lcd_rgb),
        .trace_valid (trace_valid),
        .trace_x     (trace_x),
        .trace_y     (trace_y),
        .frame_done  (frame_done),
        .frame_lines (frame_lines),
        .trace_cnt   (trace_cnt),
        .h_err       (h_err),
        .v_err       (v_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        longint stamp;
        int     x;
        int     y;
    } trace_ev_t;

    typedef struct {
        longint stamp;
        int     lines;
        int     tcnt;
        int     herr;
        int     verr;
    } frame_ev_t;

    trace_ev_t tq[$];
    frame_ev_t fq[$];
    int        frame_lens[$];

    longint cyc   = 0;
    int     total = 0;
    int     bad   = 0;
    int     m_lines = 0;
    int     m_tcnt  = 0;
    int     m_herr  = 0;
    int     m_verr  = 0;
    bit     armed       = 1'b0;
    bit     prev_vs_act = 1'b0;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] rand_rgb();
        logic [23:0] v;
        do v = 24'($urandom); while (v == TRACE);
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // One pixel clock of stimulus. A frame only counts once the decoder has seen vs leave its active level.
    task automatic px(input logic de, input logic vs_act, input logic [23:0] rgb);
        @(negedge sys_clk);
        lcd_de  = de;
        lcd_vs  = vs_act ? 1'b0 : 1'b1;
        lcd_rgb = rgb;
        lcd_hs  = 1'($urandom);
        if (rst_n) begin
            if (!vs_act && prev_vs_act) armed = 1'b1;
            prev_vs_act = vs_act;
        end
    endtask

    task automatic check_all_zero();
        check("rst_trace_valid", trace_valid, 0);
        check("rst_trace_x", trace_x, 0);
        check("rst_trace_y", trace_y, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_lines", frame_lines, 0);
        check("rst_trace_cnt", trace_cnt, 0);
        check("rst_h_err", h_err, 0);
        check("rst_v_err", v_err, 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge sys_clk);
        rst_n = 1'b0;
        tq.delete();
        fq.delete();
        m_lines = 0;
        m_tcnt  = 0;
        m_herr  = 0;
        m_verr  = 0;
        armed       = 1'b0;
        prev_vs_act = 1'b0;
        #1;
        check_all_zero();
        repeat (cycles) begin
            px(1'($urandom), 1'($urandom), ($urandom_range(3) == 0) ? TRACE : rand_rgb());
            #1;
            check_all_zero();
        end
    endtask

    // Leave reset in the middle of active video: vs inactive, de toggling, trace colours present.
    task automatic release_reset(input int cycles);
        @(negedge sys_clk);
        rst_n   = 1'b1;
        lcd_vs  = 1'b1;
        lcd_de  = 1'b1;
        lcd_rgb = TRACE;
        repeat (cycles) px(1'($urandom), 1'b0, ($urandom_range(1) == 0) ? TRACE : rand_rgb());
    endtask

    // tail >= 0: de-low cycles before vs goes active; tail < 0: vs goes active with de still high.
    task automatic run_frame(input int tail, input int pct, input int row,
                             input int at_l, input int at_p, input int abort_px);
        int n;
        int tcnt;
        int herr;
        int k;
        trace_ev_t te;
        frame_ev_t fe;
        n    = frame_lens.size();
        tcnt = 0;
        herr = 0;
        k    = 0;
        px(1'b0, 1'b0, rand_rgb());
        px(1'b0, 1'b0, rand_rgb());
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < frame_lens[l]; p++) begin
                bit t;
                t = (l == row) || (l == at_l && p == at_p) || ($urandom_range(99) < pct);
                px(1'b1, 1'b0, t ? TRACE : rand_rgb());
                if (t && armed) begin
                    te.stamp = cyc + 3;
                    te.x     = sat(p);
                    te.y     = sat(l);
                    tq.push_back(te);
                    tcnt++;
                end
                k++;
                if (k == abort_px) begin
                    do_reset(3);
                    return;
                end
            end
            if (frame_lens[l] != H) herr = 1;
            if (l < n - 1) repeat ($urandom_range(3, 1)) px(1'b0, 1'b0, rand_rgb());
        end
        if (tail < 0) begin
            px(1'b1, 1'b1, TRACE);
        end else begin
            repeat (tail) px(1'b0, 1'b0, rand_rgb());
            px(1'b0, 1'b1, rand_rgb());
        end
        if (armed) begin
            fe.stamp = cyc + 3;
            fe.lines = sat(n);
            fe.tcnt  = tcnt;
            fe.herr  = herr;
            fe.verr  = (n != V) ? 1 : 0;
            fq.push_back(fe);
        end
        if (tail < 0) px(1'b1, 1'b1, TRACE);
        px(1'b0, 1'b1, rand_rgb());
        px(1'b0, 1'b1, rand_rgb());
    endtask

    task automatic set_lens(input int n, input int len);
        frame_lens.delete();
        repeat (n) frame_lens.push_back(len);
    endtask

    // Every out-of-reset cycle: strobes must match the expected queues exactly and the summary must hold.
    initial begin
        bit exp_tv;
        bit exp_fd;
        forever begin
            @(negedge sys_clk);
            if (rst_n) begin
                exp_tv = (tq.size() > 0) && (tq[0].stamp == cyc);
                check("trace_valid", trace_valid, exp_tv);
                if (exp_tv) begin
                    check("trace_x", trace_x, tq[0].x);
                    check("trace_y", trace_y, tq[0].y);
                    void'(tq.pop_front());
                end
                exp_fd = (fq.size() > 0) && (fq[0].stamp == cyc);
                check("frame_done", frame_done, exp_fd);
                if (exp_fd) begin
                    m_lines = fq[0].lines;
                    m_tcnt  = fq[0].tcnt;
                    m_herr  = fq[0].herr;
                    m_verr  = fq[0].verr;
                    void'(fq.pop_front());
                end
                check("frame_lines", frame_lines, m_lines);
                check("trace_cnt", trace_cnt, m_tcnt);
                check("h_err", h_err, m_herr);
                check("v_err", v_err, m_verr);
            end
        end
    end

    initial begin
        do_reset(8);
        release_reset(12);
        set_lens(2, H);
        run_frame(1, 20, -1, -1, -1, -1);

        set_lens(4, H);
        run_frame(1, 0, -1, -1, -1, -1);
        run_frame(1, 0, -1, 2, 3, -1);

        frame_lens = '{8, 7, 8, 8};
        run_frame(2, 0, -1, -1, -1, -1);
        set_lens(4, H);
        run_frame(1, 0, -1, -1, -1, -1);

        set_lens(5, H);
        run_frame(0, 0, -1, -1, -1, -1);

        set_lens(4, H);
        run_frame(1, 0, 1, -1, -1, -1);
        run_frame(-1, 10, -1, -1, -1, -1);

        frame_lens = '{2100, 8, 8, 8};
        run_frame(1, 0, -1, 0, 2099, -1);
        set_lens(2050, 1);
        run_frame(1, 0, -1, -1, -1, -1);

        for (int f = 0; f < 25; f++) begin
            frame_lens.delete();
            repeat ($urandom_range(5, 3))
                frame_lens.push_back(($urandom_range(9) < 8) ? H : int'($urandom_range(10, 6)));
            run_frame(int'($urandom_range(3)) - 1, 8, -1, -1, -1, -1);
        end

        set_lens(4, H);
        run_frame(1, 30, -1, -1, -1, 13);
        release_reset(9);
        run_frame(1, 20, -1, -1, -1, -1);
        run_frame(1, 20, -1, -1, -1, -1);

        repeat (6) px(1'b0, 1'b1, rand_rgb());
        check("trace_queue_drained", tq.size(), 0);
        check("frame_queue_drained", fq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_frame_decoder.md
# lcd_frame_decoder

Pixel-stream receiver for the 1024x600 RGB LCD interface driven by `function_generator_top`. It sits on the panel side of `lcd_de`/`lcd_hs`/`lcd_vs`/`lcd_rgb` and checks frame geometry. It also reports the position of every waveform-trace pixel, so the rendered waveform can be checked in hardware or in simulation. Per-frame results are posted as a one-cycle summary pulse.

## Interface
- `H_ACTIVE`, 1024, expected `lcd_de`-high pixels per line
- `V_ACTIVE`, 600, expected active lines per frame
- `TRACE_COLOR`, 24'hFFFF00, RGB value identifying a trace pixel
- `SYNC_ACTIVE`, 1'b0, active level of `lcd_vs`
- `sys_clk  in  1  pixel clock; connected to lcd_clk. Single clock; no other clock domain.`
- `rst_n  in  1  asynchronous, active-low reset`
- `lcd_de  in  1  data enable`
- `lcd_vs  in  1  vertical sync`
- `lcd_hs  in  1  horizontal sync; unused for decoding, registered only`
- `lcd_rgb  in  24  pixel data`
- `trace_valid  out  1  one-cycle strobe: trace pixel found`
- `trace_x  out  11  column of trace pixel (0-based)`
- `trace_y  out  11  line of trace pixel (0-based)`
- `frame_done  out  1  one-cycle strobe: frame closed`
- `frame_lines  out  11  active lines counted in the closed frame`
- `trace_cnt  out  20  trace pixels in the closed frame`
- `h_err  out  1  some line in the closed frame had length != H_ACTIVE`
- `v_err  out  1  frame_lines != V_ACTIVE`

## Operation
- All inputs are registered once (stage s1), then once more (s2). Edges are detected by comparing s1 with s2.
- FSM states:
  - SEEK: reset state. Waits for the `lcd_vs` inactive edge, then moves to FRAME. Pixels seen in SEEK are ignored, so a partial first frame is discarded.
  - FRAME: counting state.
  - On the `lcd_vs` active edge in FRAME: close the frame, then return to FRAME-wait. A stay in the FRAME state is bounded by vs active/inactive edges. While vs is active, counters are held and pixels are ignored.
- `x_cnt`: increments on each s1 cycle with de=1. On the de falling edge, compare `x_cnt` with `H_ACTIVE`; a mismatch sets the frame's `h_err_acc`. Then clear `x_cnt` and increment `y_cnt`.
- Trace detection: an s1 cycle with de=1 and rgb==`TRACE_COLOR` in FRAME (vs inactive) produces `trace_valid`=1 with `trace_x`=current `x_cnt` and `trace_y`=`y_cnt`. It also increments `trace_acc`.
- Frame close (vs active edge in FRAME):
  - Outputs: `frame_lines`<=`y_cnt`, `trace_cnt`<=`trace_acc`, `h_err`<=`h_err_acc`, `v_err`<=(`y_cnt`!=`V_ACTIVE`). `frame_done`=1 for one cycle.
  - Accumulators and `y_cnt` clear.
  - Summary outputs hold until the next close.
- Width rules:
  - `x_cnt` and `y_cnt` are 11 bits and saturate at 2047. A saturated count is always a mismatch.
  - `trace_acc` is 20 bits and saturates at 1048575.
- Simultaneous events:
  - de falling edge and vs active edge in the same cycle: the line closes first and is included in `frame_lines` and `h_err`.
  - vs active edge while de still high: the open line is closed and counted, as if de had fallen.
- Reset mid-operation: all state clears immediately and the FSM returns to SEEK.
- Reset values: every output is 0.

## Timing
- `trace_valid`/`trace_x`/`trace_y`: rise 2 edges after the edge at which the pixel is sampled; high for exactly one cycle per trace pixel. Back-to-back trace pixels give back-to-back strobes.
- `frame_done` and summary outputs: valid 2 edges after the first edge that samples `lcd_vs` active; `frame_done` is high for exactly one cycle.
- Throughput: one pixel per clock, no stalls, no backpressure.

## Structure
- Shared package holds the geometry constants H_ACTIVE=1024 and V_ACTIVE=600 used by both the LCD driver and this block, the trace color, and the FSM state encoding (SEEK, FRAME).
- One natural sub-module: `lcd_edge_sync`. It provides the two-stage input register and rise/fall detection for de and vs.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, SYNC_ACTIVE=0.
- Reset held, random inputs -> all outputs 0. Release reset mid-frame -> no `frame_done` for the partial frame.
- Clean frame: 4 lines of 8 de-high pixels, no trace pixels, then vs low -> `frame_done` once, `frame_lines`=4, `trace_cnt`=0, `h_err`=0, `v_err`=0.
- Trace pixel at column 3 of line 2 -> `trace_valid` 2 cycles later with `trace_x`=3, `trace_y`=2. Frame close gives `trace_cnt`=1.
- Line 1 with 7 pixels -> `h_err`=1, `v_err`=0. Next clean frame -> `h_err`=0.
- 5 lines, with vs asserting in the same cycle as the last de fall -> `frame_lines`=5, `v_err`=1.
- Row of 8 consecutive trace pixels -> 8 consecutive `trace_valid` cycles, `trace_x` 0..7.
